data_memory_responder: RTL

//  Responder side of the ArmCpu data-memory interface (data_memory_addr/write_data/mem_write -> read_data).

---
 rtl/data_memory_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: CPU data-memory responder, word RAM with posted-write FIFO, forwarding and debug port
// Ports: clk, reset (async, active-high); CPU side data_memory_addr/write_data/mem_write -> read_data, stall;
// debug side dbg_valid/dbg_we/dbg_addr/dbg_wdata -> dbg_ready, dbg_rvalid, dbg_rdata; addr_err flag.
// Optional macro DMEM_ADDR_CHECK_EN enables the sticky addr_err check (otherwise addr_err is 0).
module data_memory_responder #(
  parameter int ADDR_W     = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       data_memory_addr,
  input  logic [31:0]       write_data,
  input  logic              mem_write,
  output logic [31:0]       read_data,
  output logic              stall,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              addr_err
);
  localparam int AW = $clog2(WBUF_DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic {IDLE, RESP} state_t;
  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;
  logic [ADDR_W-1:0] idx_q [WBUF_DEPTH];
  logic [31:0]       data_q [WBUF_DEPTH];
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] cpu_idx;
  logic [AW-1:0]     slot;
  logic              full, empty, push, pop, dbg_wr, dbg_rd;
  logic [31:0]       cpu_fwd, dbg_fwd;
  assign cpu_idx   = data_memory_addr[ADDR_W+1:2];
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = wr_ptr_q == rd_ptr_q;
  assign cnt       = wr_ptr_q - rd_ptr_q;
  assign stall     = mem_write && full;
  assign push      = mem_write && !full;
  assign dbg_ready = state_q == IDLE;
  assign dbg_wr    = dbg_valid && dbg_ready && dbg_we;
  assign dbg_rd    = dbg_valid && dbg_ready && !dbg_we;
  // The debug write owns the RAM write port, so draining pauses that cycle.
  assign pop       = !empty && !dbg_wr;
  assign read_data  = cpu_fwd;
  assign dbg_rvalid = state_q == RESP;
  assign dbg_rdata  = dbg_rdata_q;
  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    cpu_fwd = mem[cpu_idx];
    dbg_fwd = mem[dbg_addr];
    slot    = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      slot = rd_ptr_q[AW-1:0] + AW'(k);
      if (PW'(k) < cnt && idx_q[slot] == cpu_idx) cpu_fwd = data_q[slot];
      if (PW'(k) < cnt && idx_q[slot] == dbg_addr) dbg_fwd = data_q[slot];
    end
  end
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    state_d     = dbg_rd ? RESP : IDLE;
    dbg_rdata_d = dbg_rd ? dbg_fwd : dbg_rdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      dbg_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
  // Debug writes patch pending entries first; the same-cycle CPU push lands after, so it wins.
  always_ff @(posedge clk) begin
    if (dbg_wr) mem[dbg_addr] <= dbg_wdata;
    else if (pop) mem[idx_q[rd_ptr_q[AW-1:0]]] <= data_q[rd_ptr_q[AW-1:0]];
    for (int k = 0; k < WBUF_DEPTH; k++)
      if (dbg_wr && idx_q[k] == dbg_addr) data_q[k] <= dbg_wdata;
    if (push) begin
      idx_q[wr_ptr_q[AW-1:0]]  <= cpu_idx;
      data_q[wr_ptr_q[AW-1:0]] <= write_data;
    end
  end
`ifdef DMEM_ADDR_CHECK_EN
  logic err_q, err_d;
  always_comb err_d = err_q | (mem_write && (data_memory_addr[1:0] != 2'b00 || data_memory_addr[31:ADDR_W+2] != '0));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign addr_err = err_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_memory_addr[31:ADDR_W+2], data_memory_addr[1:0]};
  assign addr_err = 1'b0;
`endif
endmodule
